pdm_decoder: RTL
================

// Module: pdm_decoder
// PURPOSE
//  Receive end of the synth's 1-bit audio output. Converts the PDM/delta-sigma stream
//  on `data` back to signed PCM with a 3rd-order CIC decimator (3 integrators, decimate
//  by DECIM, 3 combs). Used for on-chip loopback checks of synth output and as the
//  capture front end for an external PDM pin, all in the synth clock domain.
// PARAMETERS
//  DECIM   64  decimation ratio; power of two, 32..256
//  OUT_W   16  PCM output width, signed
//  CIC_W   3*log2(DECIM)+2  internal accumulator width (derived localparam, not overridable)
// PORTS
//  clk        in   1      system clock (synth clock)
//  rst        in   1      asynchronous, active-low reset
//  data_in    in   1      PDM bit; 1 = +1, 0 = -1
//  in_valid   in   1      data_in is consumed on each clk edge where in_valid=1
//  pcm        out  OUT_W  decimated sample, signed two's complement
//  pcm_valid  out  1      one-cycle strobe; pcm is stable from this cycle until the next strobe
// BEHAVIOUR
//  - Reset (rst=0, async): integrators, combs, decimation counter, warm-up counter,
//    pcm=0, pcm_valid=0. The block leaves reset on the first clk edge after rst=1.
//  - Input mapping: x = data_in ? +1 : -1, sign-extended to CIC_W.
//  - Integrators: on an in_valid edge, i1+=x, i2+=i1, i3+=i2, each using its old value.
//    All are CIC_W wide and wrap modulo 2^CIC_W. Wrap is intentional; never saturate.
//    With no in_valid, all state holds.
//  - Decimation counter dc: 0..DECIM-1, advances only on in_valid edges, wraps to 0.
//    The edge with in_valid=1 and dc=DECIM-1 sets the internal strobe dec_stb for 1 cycle.
//  - Combs run on dec_stb: c1=i3-d1, c2=c1-d2, c3=c2-d3. Delay regs d1..d3 hold the previous
//    comb inputs. Arithmetic is modulo 2^CIC_W.
//    Result range: -DECIM^3..+DECIM^3.
//  - Scaling: s = c3 >>> (3*log2(DECIM)+1-OUT_W), arithmetic shift, then clamp to
//    [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Full-scale ones therefore give +max, not wrap.
//    Requires 3*log2(DECIM)+1 >= OUT_W. Add an elaboration-time check.
//  - Latency: pcm/pcm_valid update on edge k+2, where edge k consumed the DECIM-th bit.
//  - Warm-up: a 2-bit counter suppresses pcm_valid (and leaves pcm at 0) for the first 3
//    dec_stb after reset while the comb delays fill. The 4th and later dec_stb each produce
//    a pcm_valid. The counter saturates at 3.
//  - in_valid may drop at any time, including during the 2-cycle output pipeline. The
//    pipeline always completes, and pending outputs are neither lost nor duplicated.
//  - in_valid is legal every cycle, so back-to-back decimation periods need no gap.
//  - Reset mid-frame discards the partial frame and any in-flight output, and restarts warm-up.
// CONFIGURATION
//  PDM_DEC_SYNC_EN defined:
//    - data_in and in_valid each pass through a 2-flop synchronizer (reset to 0) before use.
//    - All latencies grow by 2 cycles.
//    - Use this for asynchronous external pins.
//  PDM_DEC_SYNC_EN undefined:
//    - Inputs are used directly; both must be synchronous to clk. No extra flops.
// TESTING (DECIM=64, OUT_W=16, in_valid=1 every cycle unless stated)
//  1 data_in=1 constant -> pcm_valid first at cycle 4*64+2 after reset release; pcm=32767 on every strobe
//  2 data_in=0 constant -> pcm=-32768 on every strobe after warm-up
//  3 data_in=1,0,1,0... -> pcm=0 after warm-up; strobes exactly 64 cycles apart
//  4 data_in pattern 1,1,1,0 repeating -> pcm=+16384 after warm-up
//  5 in_valid=1 every 3rd cycle, data_in=1 -> strobes exactly 192 cycles apart, pcm=32767;
//    no strobe during the first 3 periods
//  6 rst=0 pulse in mid-frame, then data_in=0 -> pcm=0 and pcm_valid=0 immediately;
//    next strobe 4*64+2 cycles after release, pcm=-32768
//  Repeat 1 and 6 with PDM_DEC_SYNC_EN defined; every expected cycle count grows by +2

Source files
------------

// File: rtl/pdm_decoder.sv
// pdm_decoder
//   Converts a 1-bit PDM / delta-sigma stream back to signed PCM with a
//   3rd-order CIC decimator: 3 integrators, decimate by DECIM, 3 combs,
//   then arithmetic scaling with saturation to OUT_W bits.
//
// Parameters
//   DECIM  decimation ratio, power of two in 32..256
//   OUT_W  signed PCM output width
//   CIC_W  internal accumulator width, derived as 3*log2(DECIM)+2 (localparam)
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   data_in    PDM bit, 1 = +1, 0 = -1
//   in_valid   data_in is consumed on each clk edge where this is high
//   pcm        decimated signed sample, held between strobes
//   pcm_valid  one-cycle strobe marking a new pcm value
//
// Build option
//   PDM_DEC_SYNC_EN  when defined, data_in and in_valid each pass through a
//                    2-flop synchronizer (all latencies grow by 2 cycles).

module pdm_decoder #(
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_in,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] pcm,
  output logic                    pcm_valid
);

  localparam int LOG2D = $clog2(DECIM);
  localparam int CIC_W = 3 * LOG2D + 2;
  localparam int SHIFT = 3 * LOG2D + 1 - OUT_W;

  localparam logic [LOG2D-1:0]        DC_LAST = LOG2D'(DECIM - 1);
  localparam logic signed [CIC_W-1:0] PCM_MAX = CIC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [CIC_W-1:0] PCM_MIN = -PCM_MAX - CIC_W'(1);

  if (SHIFT < 0) begin : g_chk_shift
    $error("pdm_decoder: 3*log2(DECIM)+1 must be >= OUT_W");
  end
  if (DECIM < 32 || DECIM > 256 || (DECIM & (DECIM - 1)) != 0) begin : g_chk_decim
    $error("pdm_decoder: DECIM must be a power of two in 32..256");
  end

  // Input path (optionally synchronized)
  logic bit_in;
  logic bit_vld;

`ifdef PDM_DEC_SYNC_EN
  logic [1:0] data_sync;
  logic [1:0] valid_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_sync  <= '0;
      valid_sync <= '0;
    end else begin
      data_sync  <= {data_sync[0], data_in};
      valid_sync <= {valid_sync[0], in_valid};
    end
  end

  assign bit_in  = data_sync[1];
  assign bit_vld = valid_sync[1];
`else
  assign bit_in  = data_in;
  assign bit_vld = in_valid;
`endif

  // CIC state
  logic signed [CIC_W-1:0] x;
  logic signed [CIC_W-1:0] i1, i2, i3;
  logic signed [CIC_W-1:0] d1, d2, d3;
  logic signed [CIC_W-1:0] c1, c2, c3;
  logic signed [CIC_W-1:0] c3_q;
  logic signed [CIC_W-1:0] scaled;
  logic signed [OUT_W-1:0] pcm_next;
  logic [LOG2D-1:0]        dc;
  logic                    dec_stb;
  logic                    c_vld;
  logic [1:0]              warm;

  always_comb begin
    x  = bit_in ? CIC_W'(1) : '1;
    c1 = i3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
    scaled = c3_q >>> SHIFT;
    if (scaled > PCM_MAX) begin
      pcm_next = PCM_MAX[OUT_W-1:0];
    end else if (scaled < PCM_MIN) begin
      pcm_next = PCM_MIN[OUT_W-1:0];
    end else begin
      pcm_next = scaled[OUT_W-1:0];
    end
  end

  // Pipeline: edge k integrates the last bit of a frame and raises dec_stb,
  // edge k+1 runs the combs, edge k+2 publishes pcm / pcm_valid. The later
  // stages advance regardless of in_valid so a pending output always lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      c3_q      <= '0;
      dc        <= '0;
      dec_stb   <= 1'b0;
      c_vld     <= 1'b0;
      warm      <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
    end else begin
      dec_stb <= 1'b0;
      if (bit_vld) begin
        // Each integrator accumulates the previous value of the one before it.
        i1      <= i1 + x;
        i2      <= i2 + i1;
        i3      <= i3 + i2;
        dc      <= dc + 1'b1;
        dec_stb <= (dc == DC_LAST);
      end

      c_vld <= 1'b0;
      if (dec_stb) begin
        d1   <= i3;
        d2   <= c1;
        d3   <= c2;
        c3_q <= c3;
        // First three decimated samples only prime the comb delays.
        if (warm == 2'd3) begin
          c_vld <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end

      pcm_valid <= c_vld;
      if (c_vld) begin
        pcm <= pcm_next;
      end
    end
  end

endmodule
